// File: rtl/anabellek_denetleyici_pkg.sv
// Shared types and constants for the main-memory controller.
// Holds the FSM states, the owner enum and the block geometry.
package anabellek_paket;

    typedef enum logic [2:0] {
        BOSTA,
        YAZ_BEAT,
        OKU_BEAT,
        OKU_BEKLE,
        TAMAM
    } durum_e;

    typedef enum logic {
        SAHIP_BELLEK,
        SAHIP_GETIR
    } sahip_e;

    localparam int unsigned BEAT_SAYISI   = 4;
    // Number of low address bits dropped to align to a block.
    localparam int unsigned OBEK_HIZALAMA = 4;

    function automatic logic son_beat(input logic [1:0] k);
        return k == 2'(BEAT_SAYISI - 1);
    endfunction

endpackage

// File: rtl/anabellek_denetleyici_tampon.sv
// Block buffer with a word index: loads a full block, reads word k, writes word k.
// obek_sonraki_o exposes the next-state block so the owner can latch a completed refill.
module obek_kelime_tamponu import anabellek_paket::*; #(
    parameter int unsigned KELIME_BIT = 32,
    parameter int unsigned OBEK_BIT   = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         yukle_i,
    input  logic [OBEK_BIT-1:0]          obek_i,
    input  logic                         yaz_i,
    input  logic [$clog2(BEAT_SAYISI)-1:0] indeks_i,
    input  logic [KELIME_BIT-1:0]        kelime_i,
    output logic [KELIME_BIT-1:0]        kelime_o,
    output logic [OBEK_BIT-1:0]          obek_sonraki_o
);

    logic [OBEK_BIT-1:0] tampon_q, tampon_d;

    always_comb begin
        tampon_d = tampon_q;
        if (yukle_i) begin
            tampon_d = obek_i;
        end else if (yaz_i) begin
            tampon_d[32'(indeks_i) * KELIME_BIT +: KELIME_BIT] = kelime_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tampon_q <= '0;
        end else begin
            tampon_q <= tampon_d;
        end
    end

    assign kelime_o       = tampon_q[32'(indeks_i) * KELIME_BIT +: KELIME_BIT];
    assign obek_sonraki_o = tampon_d;

endmodule

// File: rtl/anabellek_denetleyici.sv
// Main-memory controller: arbitrates memory-stage and fetch block requests and
// serialises each 128-bit block into four 32-bit beats on the memory handshake bus.
module anabellek_denetleyici import anabellek_paket::*; #(
    parameter int unsigned ADRES_BIT  = 32,
    parameter int unsigned KELIME_BIT = 32,
    parameter int unsigned OBEK_BIT   = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bellek_istek_i,
    input  logic                  bellek_oku_i,
    input  logic                  bellek_yaz_i,
    input  logic [ADRES_BIT-1:0]  bellek_adres_i,
    input  logic [OBEK_BIT-1:0]   bellek_yazilacak_obek_i,
    output logic [OBEK_BIT-1:0]   bellek_okunan_obek_o,
    output logic                  bellek_veri_hazir_o,
    output logic                  anabellek_musait_o,
    input  logic                  getir_istek_i,
    input  logic [ADRES_BIT-1:0]  getir_adres_i,
    output logic [OBEK_BIT-1:0]   getir_okunan_obek_o,
    output logic                  getir_veri_hazir_o,
    output logic                  mem_istek_o,
    output logic                  mem_yaz_o,
    output logic [ADRES_BIT-1:0]  mem_adres_o,
    output logic [KELIME_BIT-1:0] mem_yaz_veri_o,
    input  logic                  mem_kabul_i,
    input  logic [KELIME_BIT-1:0] mem_okunan_veri_i,
    input  logic                  mem_okunan_gecerli_i
);

    localparam logic [ADRES_BIT-1:0] HIZA_MASKE = ~ADRES_BIT'((1 << OBEK_HIZALAMA) - 1);

    durum_e               durum_q, durum_d;
    sahip_e               sahip_q, sahip_d;
    logic [1:0]           k_q, k_d;
    logic [ADRES_BIT-1:0] adres_q, adres_d;
    logic [OBEK_BIT-1:0]  bellek_obek_q, bellek_obek_d;
    logic [OBEK_BIT-1:0]  getir_obek_q, getir_obek_d;

    logic                  tampon_yukle, tampon_yaz, blok_tamam;
    logic [KELIME_BIT-1:0] tampon_kelime;
    logic [OBEK_BIT-1:0]   tampon_sonraki;

    obek_kelime_tamponu #(
        .KELIME_BIT (KELIME_BIT),
        .OBEK_BIT   (OBEK_BIT)
    ) u_tampon (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .yukle_i        (tampon_yukle),
        .obek_i         (bellek_yazilacak_obek_i),
        .yaz_i          (tampon_yaz),
        .indeks_i       (k_q),
        .kelime_i       (mem_okunan_veri_i),
        .kelime_o       (tampon_kelime),
        .obek_sonraki_o (tampon_sonraki)
    );

    always_comb begin
        durum_d       = durum_q;
        sahip_d       = sahip_q;
        k_d           = k_q;
        adres_d       = adres_q;
        bellek_obek_d = bellek_obek_q;
        getir_obek_d  = getir_obek_q;
        tampon_yukle  = 1'b0;
        tampon_yaz    = 1'b0;
        blok_tamam    = 1'b0;

        unique case (durum_q)
            BOSTA: begin
                if (bellek_istek_i) begin
                    adres_d = bellek_adres_i & HIZA_MASKE;
                    sahip_d = SAHIP_BELLEK;
                    k_d     = '0;
                    // Write wins when both direction bits are set.
                    case ({bellek_yaz_i, bellek_oku_i})
                        2'b10, 2'b11: begin
                            durum_d      = YAZ_BEAT;
                            tampon_yukle = 1'b1;
                        end
                        default: durum_d = OKU_BEAT;
                    endcase
                end else if (getir_istek_i) begin
                    adres_d = getir_adres_i & HIZA_MASKE;
                    sahip_d = SAHIP_GETIR;
                    k_d     = '0;
                    durum_d = OKU_BEAT;
                end
            end
            YAZ_BEAT: begin
                if (mem_kabul_i) begin
                    k_d = k_q + 2'd1;
                    if (son_beat(k_q)) durum_d = TAMAM;
                end
            end
            OKU_BEAT: begin
                if (mem_kabul_i) begin
                    if (mem_okunan_gecerli_i) begin
                        tampon_yaz = 1'b1;
                        k_d        = k_q + 2'd1;
                        blok_tamam = son_beat(k_q);
                        if (son_beat(k_q)) durum_d = TAMAM;
                    end else begin
                        durum_d = OKU_BEKLE;
                    end
                end
            end
            OKU_BEKLE: begin
                if (mem_okunan_gecerli_i) begin
                    tampon_yaz = 1'b1;
                    k_d        = k_q + 2'd1;
                    blok_tamam = son_beat(k_q);
                    durum_d    = son_beat(k_q) ? TAMAM : OKU_BEAT;
                end
            end
            TAMAM: begin
                durum_d = BOSTA;
                k_d     = '0;
            end
            default: durum_d = BOSTA;
        endcase

        // The refill outputs change only when a read completes, so they stay stable between transfers.
        if (blok_tamam) begin
            if (sahip_q == SAHIP_BELLEK) bellek_obek_d = tampon_sonraki;
            else                         getir_obek_d  = tampon_sonraki;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q       <= BOSTA;
            sahip_q       <= SAHIP_BELLEK;
            k_q           <= '0;
            adres_q       <= '0;
            bellek_obek_q <= '0;
            getir_obek_q  <= '0;
        end else begin
            durum_q       <= durum_d;
            sahip_q       <= sahip_d;
            k_q           <= k_d;
            adres_q       <= adres_d;
            bellek_obek_q <= bellek_obek_d;
            getir_obek_q  <= getir_obek_d;
        end
    end

    assign anabellek_musait_o   = (durum_q == BOSTA);
    assign mem_istek_o          = (durum_q == YAZ_BEAT) || (durum_q == OKU_BEAT);
    assign mem_yaz_o            = (durum_q == YAZ_BEAT);
    assign mem_adres_o          = mem_istek_o ? adres_q + ADRES_BIT'({k_q, 2'b00}) : '0;
    assign mem_yaz_veri_o       = mem_yaz_o ? tampon_kelime : '0;
    assign bellek_veri_hazir_o  = (durum_q == TAMAM) && (sahip_q == SAHIP_BELLEK);
    assign getir_veri_hazir_o   = (durum_q == TAMAM) && (sahip_q == SAHIP_GETIR);
    assign bellek_okunan_obek_o = bellek_obek_q;
    assign getir_okunan_obek_o  = getir_obek_q;

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Self-checking bench for anabellek_denetleyici: vector table, memory responder
// and a scoreboard of expected completions checked on each ready pulse.
module tb_anabellek_denetleyici;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         bellek_istek_i, bellek_oku_i, bellek_yaz_i;
    logic [31:0]  bellek_adres_i;
    logic [127:0] bellek_yazilacak_obek_i, bellek_okunan_obek_o;
    logic         bellek_veri_hazir_o, anabellek_musait_o;
    logic         getir_istek_i;
    logic [31:0]  getir_adres_i;
    logic [127:0] getir_okunan_obek_o;
    logic         getir_veri_hazir_o;
    logic         mem_istek_o, mem_yaz_o;
    logic [31:0]  mem_adres_o, mem_yaz_veri_o;
    logic         mem_kabul_i;
    logic [31:0]  mem_okunan_veri_i;
    logic         mem_okunan_gecerli_i;

    anabellek_denetleyici dut (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .bellek_istek_i          (bellek_istek_i),
        .bellek_oku_i            (bellek_oku_i),
        .bellek_yaz_i            (bellek_yaz_i),
        .bellek_adres_i          (bellek_adres_i),
        .bellek_yazilacak_obek_i (bellek_yazilacak_obek_i),
        .bellek_okunan_obek_o    (bellek_okunan_obek_o),
        .bellek_veri_hazir_o     (bellek_veri_hazir_o),
        .anabellek_musait_o      (anabellek_musait_o),
        .getir_istek_i           (getir_istek_i),
        .getir_adres_i           (getir_adres_i),
        .getir_okunan_obek_o     (getir_okunan_obek_o),
        .getir_veri_hazir_o      (getir_veri_hazir_o),
        .mem_istek_o             (mem_istek_o),
        .mem_yaz_o               (mem_yaz_o),
        .mem_adres_o             (mem_adres_o),
        .mem_yaz_veri_o          (mem_yaz_veri_o),
        .mem_kabul_i             (mem_kabul_i),
        .mem_okunan_veri_i       (mem_okunan_veri_i),
        .mem_okunan_gecerli_i    (mem_okunan_gecerli_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           getir;
        bit           yaz;
        logic [127:0] blok;
    } beklenti_t;

    typedef struct {
        bit          yaz;
        logic [31:0] adres;
        logic [31:0] veri;
    } beat_t;

    typedef struct {
        bit           getir;
        bit           oku;
        bit           yaz;
        logic [31:0]  adres;
        logic [127:0] blok;
        int           kabul_gec;
        int           gecerli_gec;
        logic [31:0]  taban;
        logic [127:0] beklenen;
    } vektor_t;

    beklenti_t    sb[$];
    beat_t        beat_log[$];
    logic [31:0]  mem_model [logic [31:0]];
    logic [127:0] son_bellek_blok = '0;

    int n_kars = 0;
    int n_hata = 0;
    int kabul_gec = 0;
    int gecerli_gec = 0;
    bit sahte_gecerli = 0;
    int istek_bekle_ihlal = 0;
    int beat_sayac = 0;
    int toplam_hazir = 0;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_kars++;
        if (gercek !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    task automatic kontrol_obek(input string ad, input logic [127:0] gercek,
                                input logic [127:0] beklenen);
        n_kars++;
        if (gercek !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    function automatic logic [31:0] model_oku(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: kabul after kabul_gec waiting cycles, gecerli gecerli_gec cycles after kabul.
    initial begin
        int          bekle = 0;
        int          gsay = 0;
        bit          bekliyor = 0;
        logic [31:0] bveri = '0;
        logic [31:0] tut_adres = '0;
        logic [31:0] tut_veri = '0;
        mem_kabul_i = 0;
        mem_okunan_gecerli_i = 0;
        mem_okunan_veri_i = '0;
        forever begin
            @(negedge clk);
            mem_kabul_i = 0;
            mem_okunan_gecerli_i = 0;
            mem_okunan_veri_i = '0;
            if (!rst_i) begin
                bekle = 0;
                bekliyor = 0;
            end else if (sahte_gecerli) begin
                mem_okunan_gecerli_i = 1;
                mem_okunan_veri_i = 32'hDEAD_BEEF;
                sahte_gecerli = 0;
            end else if (bekliyor) begin
                if (mem_istek_o) istek_bekle_ihlal++;
                if (gsay == 0) begin
                    mem_okunan_gecerli_i = 1;
                    mem_okunan_veri_i = bveri;
                    bekliyor = 0;
                end else begin
                    gsay--;
                end
            end else if (mem_istek_o) begin
                if (bekle > 0 && mem_yaz_o) begin
                    kontrol("yaz_tutma_adres", mem_adres_o, tut_adres);
                    kontrol("yaz_tutma_veri", mem_yaz_veri_o, tut_veri);
                end
                if (bekle < kabul_gec) begin
                    bekle++;
                    tut_adres = mem_adres_o;
                    tut_veri = mem_yaz_veri_o;
                end else begin
                    bekle = 0;
                    mem_kabul_i = 1;
                    beat_sayac++;
                    beat_log.push_back('{mem_yaz_o, mem_adres_o, mem_yaz_veri_o});
                    if (mem_yaz_o) begin
                        mem_model[mem_adres_o] = mem_yaz_veri_o;
                    end else begin
                        bveri = model_oku(mem_adres_o);
                        if (gecerli_gec == 0) begin
                            mem_okunan_gecerli_i = 1;
                            mem_okunan_veri_i = bveri;
                        end else begin
                            bekliyor = 1;
                            gsay = gecerli_gec - 1;
                        end
                    end
                end
            end
        end
    end

    // Scoreboard: every ready pulse pops one expectation.
    initial begin
        beklenti_t e;
        forever begin
            @(negedge clk);
            if (rst_i && (bellek_veri_hazir_o || getir_veri_hazir_o)) begin
                toplam_hazir++;
                kontrol("tek_hazir", 32'(bellek_veri_hazir_o & getir_veri_hazir_o), 32'd0);
                if (sb.size() == 0) begin
                    n_kars++;
                    n_hata++;
                    $display("FAIL beklenmeyen_hazir: got pulse bellek=%0b getir=%0b expected none",
                             bellek_veri_hazir_o, getir_veri_hazir_o);
                end else begin
                    e = sb.pop_front();
                    kontrol("hazir_sahip", 32'(getir_veri_hazir_o), 32'(e.getir));
                    kontrol("beat_sayisi", beat_sayac, 32'd4);
                    if (e.getir) kontrol_obek("getir_obek", getir_okunan_obek_o, e.blok);
                    else         kontrol_obek("bellek_obek", bellek_okunan_obek_o, e.blok);
                end
                beat_sayac = 0;
            end
        end
    end

    task automatic bekle_ekle(input bit getir, input bit yaz, input logic [127:0] blok);
        if (!getir && yaz) begin
            sb.push_back('{getir, yaz, son_bellek_blok});
        end else begin
            sb.push_back('{getir, yaz, blok});
            if (!getir) son_bellek_blok = blok;
        end
    endtask

    // Call at a negedge; holds the request until its ready pulse or the cycle budget expires.
    task automatic istek(input bit getir, input logic [31:0] adres, input bit oku, input bit yaz,
                         input logic [127:0] blok, output int gecikme);
        bit goruldu = 0;
        if (!getir) begin
            bellek_istek_i = 1;
            bellek_adres_i = adres;
            bellek_oku_i = oku;
            bellek_yaz_i = yaz;
            bellek_yazilacak_obek_i = blok;
        end else begin
            getir_istek_i = 1;
            getir_adres_i = adres;
        end
        gecikme = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            gecikme++;
            if (getir ? getir_veri_hazir_o : bellek_veri_hazir_o) begin
                goruldu = 1;
                break;
            end
        end
        kontrol("hazir_zaman_asimi", 32'(goruldu), 32'd1);
        if (!getir) begin
            bellek_istek_i = 0;
            bellek_oku_i = 0;
            bellek_yaz_i = 0;
        end else begin
            getir_istek_i = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    vektor_t vek[6];

    initial begin
        int g, g1, g2;
        vek[0] = '{0, 1, 0, 32'h0000_1234, '0, 0, 0, 32'h1230,
                   128'h00000044_00000033_00000022_00000011};
        vek[1] = '{0, 0, 1, 32'h0000_2000,
                   128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 2, 0, 32'h2000,
                   128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};
        vek[2] = '{0, 1, 1, 32'h0000_3008,
                   128'h99990003_99990002_99990001_99990000, 0, 0, 32'h3000,
                   128'h99990003_99990002_99990001_99990000};
        vek[3] = '{1, 0, 0, 32'h0000_4004, '0, 0, 3, 32'h4000,
                   128'h5A5A400C_5A5A4008_5A5A4004_5A5A4000};
        vek[4] = '{0, 1, 0, 32'h0000_200F, '0, 1, 1, 32'h2000,
                   128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};
        vek[5] = '{1, 0, 0, 32'h0000_1230, '0, 0, 0, 32'h1230,
                   128'h00000044_00000033_00000022_00000011};

        mem_model[32'h1230] = 32'h11;
        mem_model[32'h1234] = 32'h22;
        mem_model[32'h1238] = 32'h33;
        mem_model[32'h123C] = 32'h44;

        rst_i = 0;
        bellek_istek_i = 0; bellek_oku_i = 0; bellek_yaz_i = 0;
        bellek_adres_i = '0; bellek_yazilacak_obek_i = '0;
        getir_istek_i = 0; getir_adres_i = '0;
        #2;
        kontrol("rst_musait", 32'(anabellek_musait_o), 32'd1);
        kontrol("rst_mem_istek", 32'(mem_istek_o), 32'd0);
        kontrol("rst_mem_yaz", 32'(mem_yaz_o), 32'd0);
        kontrol("rst_mem_adres", mem_adres_o, 32'd0);
        kontrol("rst_mem_yaz_veri", mem_yaz_veri_o, 32'd0);
        kontrol("rst_hazir", 32'({bellek_veri_hazir_o, getir_veri_hazir_o}), 32'd0);
        kontrol_obek("rst_bellek_obek", bellek_okunan_obek_o, '0);
        kontrol_obek("rst_getir_obek", getir_okunan_obek_o, '0);
        repeat (2) @(negedge clk);
        rst_i = 1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            kabul_gec = vek[i].kabul_gec;
            gecerli_gec = vek[i].gecerli_gec;
            beat_log.delete();
            bekle_ekle(vek[i].getir, vek[i].yaz, vek[i].beklenen);
            istek(vek[i].getir, vek[i].adres, vek[i].oku, vek[i].yaz, vek[i].blok, g);
            if (vek[i].kabul_gec == 0 && vek[i].gecerli_gec == 0) kontrol("gecikme", g, 32'd6);
            kontrol("beat_adedi", beat_log.size(), 32'd4);
            for (int k = 0; k < beat_log.size() && k < 4; k++) begin
                kontrol("beat_adres", beat_log[k].adres, vek[i].taban + 32'(4 * k));
                kontrol("beat_yaz", 32'(beat_log[k].yaz), 32'(vek[i].yaz));
                if (vek[i].yaz) kontrol("beat_veri", beat_log[k].veri, vek[i].beklenen[32 * k +: 32]);
            end
            @(negedge clk);
            kontrol("musait_sonra", 32'(anabellek_musait_o), 32'd1);
        end

        // Both requestors rise together: memory stage first, then fetch.
        @(negedge clk);
        kabul_gec = 0; gecerli_gec = 0;
        beat_log.delete();
        bekle_ekle(0, 0, 128'h00000044_00000033_00000022_00000011);
        bekle_ekle(1, 0, 128'h5A5A500C_5A5A5008_5A5A5004_5A5A5000);
        fork
            istek(0, 32'h0000_1230, 1, 0, '0, g1);
            istek(1, 32'h0000_5000, 0, 0, '0, g2);
        join
        kontrol("esz_beat_adedi", beat_log.size(), 32'd8);
        if (beat_log.size() == 8) begin
            kontrol("esz_ilk_adres", beat_log[0].adres, 32'h1230);
            kontrol("esz_ikinci_adres", beat_log[4].adres, 32'h5000);
        end

        // Spurious gecerli while idle, then a read with gecerli 3 cycles after kabul.
        @(negedge clk);
        sahte_gecerli = 1;
        repeat (2) @(negedge clk);
        kabul_gec = 0; gecerli_gec = 3;
        istek_bekle_ihlal = 0;
        beat_log.delete();
        bekle_ekle(0, 0, 128'h5A5A600C_5A5A6008_5A5A6004_5A5A6000);
        istek(0, 32'h0000_6000, 1, 0, '0, g);
        kontrol("bekle_istek_sifir", istek_bekle_ihlal, 32'd0);

        // Reset asserted during the second beat of a read aborts it silently.
        @(negedge clk);
        kabul_gec = 3; gecerli_gec = 2;
        beat_log.delete();
        g = toplam_hazir;
        bellek_istek_i = 1; bellek_oku_i = 1; bellek_yaz_i = 0; bellek_adres_i = 32'h0000_7000;
        g1 = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (beat_log.size() == 1 && mem_istek_o && mem_adres_o == 32'h7004) begin
                g1 = 1;
                break;
            end
        end
        kontrol("ikinci_beat_bulundu", g1, 32'd1);
        rst_i = 0;
        #1;
        kontrol("abort_mem_istek", 32'(mem_istek_o), 32'd0);
        kontrol("abort_musait", 32'(anabellek_musait_o), 32'd1);
        kontrol("abort_hazir", 32'(bellek_veri_hazir_o), 32'd0);
        bellek_istek_i = 0; bellek_oku_i = 0;
        son_bellek_blok = '0;
        @(negedge clk);
        rst_i = 1;
        beat_sayac = 0;
        repeat (8) @(negedge clk);
        kontrol("abort_pulse_yok", toplam_hazir, g);
        kontrol_obek("abort_obek_sifir", bellek_okunan_obek_o, '0);

        kabul_gec = 0; gecerli_gec = 0;
        beat_log.delete();
        bekle_ekle(0, 0, 128'h00000044_00000033_00000022_00000011);
        istek(0, 32'h0000_1230, 1, 0, '0, g);
        kontrol("reset_sonrasi_gecikme", g, 32'd6);

        repeat (3) @(negedge clk);
        kontrol("sb_bos", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_kars, n_hata);
        $finish;
    end

endmodule
